// File: rtl/exu_alu_pkg.sv
// Shared types and helpers for the multi-cycle EXU ALU.
// Operation encoding, FSM states and op-class predicates.
package exu_alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int SHAMT_W  = $clog2(XLEN_DEF);

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_BEQ,
        ALU_BNE,
        ALU_BLT,
        ALU_BGE,
        ALU_BLTU,
        ALU_BGEU,
        ALU_JAL,
        ALU_PASSB
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_e;

    function automatic logic is_shift(alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic logic is_branch(alu_op_e op);
        return (op == ALU_BEQ) || (op == ALU_BNE) ||
               (op == ALU_BLT) || (op == ALU_BGE) ||
               (op == ALU_BLTU) || (op == ALU_BGEU);
    endfunction

endpackage

// File: rtl/exu_alu_iter_shift.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle.
// done flags the final step; result is the value that step produces.
module exu_alu_iter_shift
    import exu_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     kill,
    input  alu_op_e                  op,
    input  logic [XLEN-1:0]          a,
    input  logic [$clog2(XLEN)-1:0]  shamt,
    output logic                     busy,
    output logic                     done,
    output logic [XLEN-1:0]          result
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

    alu_op_e         op_q;
    logic [XLEN-1:0] work;
    logic [SHW-1:0]  cnt;
    logic [SHW:0]    step;
    logic [XLEN-1:0] shifted;

    always_comb begin
        step = ({1'b0, cnt} < STEP) ? {1'b0, cnt} : STEP;
        case (op_q)
            ALU_SLL: shifted = work << step;
            ALU_SRA: shifted = $unsigned($signed(work) >>> step);
            default: shifted = work >> step;
        endcase
    end

    assign done   = busy & ({1'b0, cnt} <= STEP);
    assign result = shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            work <= '0;
            op_q <= ALU_SLL;
        end else if (kill) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= shamt;
            work <= a;
            op_q <= op;
        end else if (busy) begin
            work <= shifted;
            cnt  <= cnt - step[SHW-1:0];
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/exu_alu_mc_ctl.sv
// EXU ALU with iterative shifts, branch resolve and JAL link.
// One result register behind a valid/ready handshake; flush kills in-flight work.
module exu_alu_mc_ctl
    import exu_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int BRIMM_W    = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  alu_op_e            op,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    input  logic [XLEN-2:0]    pc,
    input  logic [BRIMM_W-1:0] brimm,
    input  logic               is_rvc,
    input  logic               predict_t,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out,
    output logic               flush_upper,
    output logic [XLEN-2:0]    flush_path,
    output logic               pred_correct
);

    localparam int SHW      = $clog2(XLEN);
    localparam bit SC_SHIFT = (SHIFT_STEP == XLEN);

    state_e          state, state_nx;
    logic            acc, long_sh, load_sh;
    logic            sh_busy, sh_done;
    logic [XLEN-1:0] sh_res, barrel, sc_res, res_nx;
    logic [XLEN-1:0] sum, diff;
    logic            eq, lt, ltu, taken;
    logic [XLEN-2:0] inc, imm_x, link_hw, tgt, fpath_nx;
    logic            redir_nx, pok_nx;
    logic [XLEN-1:0] out_q;
    logic [XLEN-2:0] fpath_q;
    logic            pok_q, fu_q;

    assign acc     = in_valid & in_ready & ~flush;
    assign long_sh = is_shift(op) & (b[SHW-1:0] != '0) & ~SC_SHIFT;
    assign load_sh = (state == SHIFT) & sh_done & ~flush;

    assign sum  = a + b;
    assign diff = a - b;
    assign eq   = (a == b);
    assign lt   = $signed(a) < $signed(b);
    assign ltu  = a < b;

    assign inc     = is_rvc ? (XLEN-1)'(1) : (XLEN-1)'(2);
    assign imm_x   = {{(XLEN-1-BRIMM_W){brimm[BRIMM_W-1]}}, brimm};
    assign link_hw = pc + inc;
    assign tgt     = pc + imm_x;

    always_comb begin
        case (op)
            ALU_SLL: barrel = a << b[SHW-1:0];
            ALU_SRA: barrel = $unsigned($signed(a) >>> b[SHW-1:0]);
            default: barrel = a >> b[SHW-1:0];
        endcase
        // only a full-width step gets a barrel; otherwise this path sees shamt==0
        sc_res = SC_SHIFT ? barrel : a;
    end

    always_comb begin
        case (op)
            ALU_BEQ:  taken = eq;
            ALU_BNE:  taken = ~eq;
            ALU_BLT:  taken = lt;
            ALU_BGE:  taken = ~lt;
            ALU_BLTU: taken = ltu;
            ALU_BGEU: taken = ~ltu;
            default:  taken = 1'b0;
        endcase
    end

    always_comb begin
        res_nx = '0;
        case (op)
            ALU_ADD:   res_nx = sum;
            ALU_SUB:   res_nx = diff;
            ALU_AND:   res_nx = a & b;
            ALU_OR:    res_nx = a | b;
            ALU_XOR:   res_nx = a ^ b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   res_nx = sc_res;
            ALU_SLT:   res_nx = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU:  res_nx = {{(XLEN-1){1'b0}}, ltu};
            ALU_JAL:   res_nx = {link_hw, 1'b0};
            ALU_PASSB: res_nx = b;
            default:   res_nx = '0;
        endcase
    end

    always_comb begin
        fpath_nx = taken ? tgt : link_hw;
        redir_nx = 1'b0;
        pok_nx   = 1'b1;
        if (op == ALU_JAL) begin
            fpath_nx = sum[XLEN-1:1];
            redir_nx = 1'b1;
            pok_nx   = 1'b0;
        end else if (is_branch(op)) begin
            redir_nx = (taken != predict_t);
            pok_nx   = ~redir_nx;
        end
    end

    exu_alu_iter_shift #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .start  (acc & long_sh),
        .kill   (flush),
        .op     (op),
        .a      (a),
        .shamt  (b[SHW-1:0]),
        .busy   (sh_busy),
        .done   (sh_done),
        .result (sh_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (acc) state_nx = long_sh ? SHIFT : HOLD;
            end
            SHIFT: begin
                if (!sh_busy)    state_nx = IDLE;
                else if (sh_done) state_nx = HOLD;
            end
            HOLD: begin
                if (acc)            state_nx = long_sh ? SHIFT : HOLD;
                else if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_comb begin
        in_ready    = (state == IDLE) | ((state == HOLD) & out_ready);
        out_valid   = (state == HOLD);
        flush_upper = fu_q & ~flush;
    end

    // redirect pulse is armed only when a result is loaded, so stalls never repeat it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            fpath_q <= '0;
            pok_q   <= 1'b0;
            fu_q    <= 1'b0;
        end else begin
            fu_q <= 1'b0;
            if (acc & ~long_sh) begin
                out_q   <= res_nx;
                fpath_q <= fpath_nx;
                pok_q   <= pok_nx;
                fu_q    <= redir_nx;
            end else if (load_sh) begin
                out_q <= sh_res;
                pok_q <= 1'b1;
            end
        end
    end

    assign out          = out_q;
    assign flush_path   = fpath_q;
    assign pred_correct = pok_q;

endmodule

// File: tb/tb_exu_alu_mc_ctl.sv
// Directed bench for exu_alu_mc_ctl: a SHIFT_STEP=1 and a SHIFT_STEP=8 instance.
// Expected values are hand-computed constants.
module tb_exu_alu_mc_ctl;
    import exu_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid, in_valid8;
    alu_op_e     op;
    logic [31:0] a, b;
    logic [30:0] pc;
    logic [11:0] brimm;
    logic        is_rvc, predict_t, out_ready;

    logic        in_ready, out_valid, flush_upper, pred_correct;
    logic [31:0] res;
    logic [30:0] flush_path;
    logic        in_ready8, out_valid8, flush_upper8, pred_correct8;
    logic [31:0] res8;
    logic [30:0] flush_path8;

    int n_chk = 0;
    int n_fail = 0;
    int n;

    always #5 clk = ~clk;

    exu_alu_mc_ctl #(.XLEN(32), .SHIFT_STEP(1), .BRIMM_W(12)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .pc(pc), .brimm(brimm),
        .is_rvc(is_rvc), .predict_t(predict_t),
        .out_valid(out_valid), .out_ready(out_ready), .out(res),
        .flush_upper(flush_upper), .flush_path(flush_path),
        .pred_correct(pred_correct)
    );

    exu_alu_mc_ctl #(.XLEN(32), .SHIFT_STEP(8), .BRIMM_W(12)) dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op), .a(a), .b(b), .pc(pc), .brimm(brimm),
        .is_rvc(is_rvc), .predict_t(predict_t),
        .out_valid(out_valid8), .out_ready(out_ready), .out(res8),
        .flush_upper(flush_upper8), .flush_path(flush_path8),
        .pred_correct(pred_correct8)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input alu_op_e o, input logic [31:0] x,
                        input logic [31:0] y);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        tick();
        in_valid = 1'b0;
    endtask

    alu_op_e     t_op  [7] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                               ALU_SLT, ALU_SLTU, ALU_PASSB};
    logic [31:0] t_a   [7] = '{32'h3, 32'hF0F0F0F0, 32'hF0F0F0F0,
                               32'hF0F0F0F0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9};
    logic [31:0] t_b   [7] = '{32'h5, 32'h0FF00FF0, 32'h0FF00FF0,
                               32'h0FF00FF0, 32'h1, 32'h1, 32'h1234};
    logic [31:0] t_exp [7] = '{32'hFFFFFFFE, 32'h00F000F0, 32'hFFF0FFF0,
                               32'hFF00FF00, 32'h1, 32'h0, 32'h1234};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0;
        op = ALU_ADD; a = '0; b = '0; pc = '0; brimm = '0;
        is_rvc = 1'b0; predict_t = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", res, 0);
        chk("rst_flush_upper", flush_upper, 0);
        chk("rst_flush_path", flush_path, 0);
        chk("rst_pred_correct", pred_correct, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // ADD wrap, latency 1
        send(ALU_ADD, 32'hFFFFFFFF, 32'h1);
        chk("add_valid", out_valid, 1);
        chk("add_out", res, 0);
        chk("add_in_ready", in_ready, 1);
        tick();
        chk("add_idle", out_valid, 0);

        // op table, back-to-back
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            op = t_op[i]; a = t_a[i]; b = t_b[i];
            tick();
            chk($sformatf("tbl%0d_valid", i), out_valid, 1);
            chk($sformatf("tbl%0d_out", i), res, t_exp[i]);
        end
        in_valid = 1'b0;
        tick();

        // SRA 31, step 1
        send(ALU_SRA, 32'h80000000, 32'd31);
        n = 0;
        while (!in_ready && n < 100) begin n++; tick(); end
        chk("sra1_cycles", n, 31);
        chk("sra1_valid", out_valid, 1);
        chk("sra1_out", res, 32'hFFFFFFFF);
        tick();

        // SRA 31, step 8
        in_valid8 = 1'b1; op = ALU_SRA; a = 32'h80000000; b = 32'd31;
        tick();
        in_valid8 = 1'b0;
        n = 0;
        while (!in_ready8 && n < 100) begin n++; tick(); end
        chk("sra8_cycles", n, 4);
        chk("sra8_valid", out_valid8, 1);
        chk("sra8_out", res8, 32'hFFFFFFFF);
        tick();

        // SLL 4 and SRL by 0
        send(ALU_SLL, 32'h1, 32'd4);
        n = 0;
        while (!in_ready && n < 100) begin n++; tick(); end
        chk("sll_cycles", n, 4);
        chk("sll_out", res, 32'h10);
        tick();
        send(ALU_SRL, 32'hABCD, 32'd32);
        chk("srl0_valid", out_valid, 1);
        chk("srl0_out", res, 32'hABCD);
        tick();

        // BLT mispredict with 5-cycle stall
        out_ready = 1'b0; predict_t = 1'b0;
        pc = 31'h800; brimm = 12'h8;
        send(ALU_BLT, 32'hFFFFFFFF, 32'h0);
        chk("blt_valid", out_valid, 1);
        chk("blt_out", res, 0);
        chk("blt_flush_upper", flush_upper, 1);
        chk("blt_flush_path", flush_path, 31'h808);
        chk("blt_pred", pred_correct, 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (flush_upper) n++;
        end
        chk("stall_repulse", n, 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_path", flush_path, 31'h808);
        out_ready = 1'b1;
        tick();
        chk("stall_release", out_valid, 0);

        // BEQ correctly predicted not-taken
        send(ALU_BEQ, 32'h1, 32'h2);
        chk("beq_flush_upper", flush_upper, 0);
        chk("beq_pred", pred_correct, 1);
        // BGEU taken, negative offset
        brimm = 12'hFF8;
        send(ALU_BGEU, 32'h5, 32'h3);
        chk("bgeu_flush_upper", flush_upper, 1);
        chk("bgeu_path", flush_path, 31'h7F8);
        // BNE predicted taken, falls through
        predict_t = 1'b1;
        send(ALU_BNE, 32'h7, 32'h7);
        chk("bne_flush_upper", flush_upper, 1);
        chk("bne_path", flush_path, 31'h802);
        chk("bne_pred", pred_correct, 0);
        predict_t = 1'b0;
        tick();

        // flush mid-SHIFT with same-cycle issue
        send(ALU_SLL, 32'h1, 32'd10);
        tick(); tick();
        flush = 1'b1; in_valid = 1'b1; op = ALU_ADD; a = 32'h3; b = 32'h4;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle", in_ready, 1);
        chk("flush_valid", out_valid, 0);
        tick();
        chk("flush_noacc", out_valid, 0);

        // flush suppresses a pending flush_upper
        out_ready = 1'b0; brimm = 12'h8;
        send(ALU_BLT, 32'hFFFFFFFF, 32'h0);
        chk("sup_pre", flush_upper, 1);
        flush = 1'b1;
        #1;
        chk("sup_flush", flush_upper, 0);
        tick();
        flush = 1'b0;
        chk("sup_valid", out_valid, 0);
        out_ready = 1'b1;

        // back-to-back ADD, SLTU, JAL
        in_valid = 1'b1; op = ALU_ADD; a = 32'h5; b = 32'h6;
        tick();
        chk("b2b_add_v", out_valid, 1);
        chk("b2b_add", res, 32'd11);
        op = ALU_SLTU; a = 32'h1; b = 32'h2;
        tick();
        chk("b2b_sltu_v", out_valid, 1);
        chk("b2b_sltu", res, 1);
        op = ALU_JAL; a = 32'h100; b = 32'h20; is_rvc = 1'b1; pc = 31'h1000;
        tick();
        in_valid = 1'b0;
        chk("b2b_jal_v", out_valid, 1);
        chk("b2b_jal", res, 32'h2002);
        chk("jal_flush_upper", flush_upper, 1);
        chk("jal_path", flush_path, 31'h90);
        chk("jal_pred", pred_correct, 0);
        tick();
        chk("b2b_end", out_valid, 0);
        is_rvc = 1'b0;

        // reset mid-SHIFT
        send(ALU_SLL, 32'h1, 32'd20);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("rstsh_valid", out_valid, 0);
        chk("rstsh_ready", in_ready, 1);
        chk("rstsh_out", res, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstsh_after", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
